// File: rtl/oflow_iou_best_match_if.sv
// Bundle of the handshake and data signals between the IoU cost source, the
// best-match selector and the downstream association stage.
//   master : drives start/num_candidates/cost_threshold/valid_iou/iou,
//            observes ready/done and the result fields.
//   slave  : the best-match selector itself.
interface oflow_iou_best_match_if #(
   parameter int unsigned IOU_LEN     = 22,
   parameter int unsigned CAND_ID_LEN = 4
);
   logic                   start;
   logic [CAND_ID_LEN:0]   num_candidates;
   logic [IOU_LEN-1:0]     cost_threshold;
   logic                   valid_iou;
   logic [IOU_LEN-1:0]     iou;
   logic                   ready;
   logic                   done;
   logic                   match_found;
   logic [CAND_ID_LEN-1:0] best_id;
   logic [IOU_LEN-1:0]     best_cost;
   logic                   timeout;

   modport master (
      output start, num_candidates, cost_threshold, valid_iou, iou,
      input  ready, done, match_found, best_id, best_cost, timeout
   );

   modport slave (
      input  start, num_candidates, cost_threshold, valid_iou, iou,
      output ready, done, match_found, best_id, best_cost, timeout
   );
endinterface

// File: rtl/oflow_iou_best_match.sv
// Best-match selector for one frame-k object against up to MAX_CANDIDATES
// history candidates. Costs are (all-ones - scaled IoU), so the minimum cost
// is the best overlap. After the last cost (or an idle timeout) a thresholded
// decision is registered and announced with a one-cycle done pulse.
// Ports:
//   clk     : rising-edge clock
//   reset_N : asynchronous active-low reset
//   bus     : slave side of oflow_iou_best_match_if (start/num/threshold,
//             valid_iou/iou in; ready/done/match_found/best_id/best_cost/
//             timeout out)
module oflow_iou_best_match #(
   parameter int unsigned IOU_LEN        = 22,
   parameter int unsigned MAX_CANDIDATES = 16,
   parameter int unsigned CAND_ID_LEN    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TO_CNT_LEN     = 7
) (
   input logic                   clk,
   input logic                   reset_N,
   oflow_iou_best_match_if.slave bus
);

   localparam int unsigned CntW = CAND_ID_LEN + 1;
   localparam logic [CntW-1:0]       MaxCand = CntW'(MAX_CANDIDATES);
   localparam logic [TO_CNT_LEN-1:0] ToLast  = TO_CNT_LEN'(TIMEOUT_CYCLES - 1);
   localparam logic [IOU_LEN-1:0]    AllOnes = '1;

   typedef enum logic [1:0] {StIdle, StCollect, StDecide, StDone} state_e;

   state_e                 state_q;
   logic [CntW-1:0]        num_q;
   logic [IOU_LEN-1:0]     thr_q;
   logic [CntW-1:0]        cand_cnt_q, cand_cnt_d;
   logic [IOU_LEN-1:0]     min_q, min_d;
   logic [CAND_ID_LEN-1:0] min_id_q, min_id_d;
   logic [TO_CNT_LEN-1:0]  to_cnt_q, to_cnt_d;
   logic                   to_flag_q;
   logic [CntW-1:0]        num_clamped;

   logic                   ready_q, done_q, match_q, timeout_q;
   logic [CAND_ID_LEN-1:0] best_id_q;
   logic [IOU_LEN-1:0]     best_cost_q;

   // Datapath next values; only committed by the FSM on a COLLECT strobe.
   always_comb begin
      cand_cnt_d  = cand_cnt_q + CntW'(1);
      to_cnt_d    = to_cnt_q + TO_CNT_LEN'(1);
      min_d       = min_q;
      min_id_d    = min_id_q;
      // Strict compare: ties keep the earlier candidate, and an all-ones cost
      // can never displace the all-ones initial minimum.
      if (bus.iou < min_q) begin
         min_d    = bus.iou;
         min_id_d = cand_cnt_q[CAND_ID_LEN-1:0];
      end
      num_clamped = (bus.num_candidates > MaxCand) ? MaxCand : bus.num_candidates;
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state_q     <= StIdle;
         num_q       <= '0;
         thr_q       <= '0;
         cand_cnt_q  <= '0;
         min_q       <= AllOnes;
         min_id_q    <= '0;
         to_cnt_q    <= '0;
         to_flag_q   <= 1'b0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         match_q     <= 1'b0;
         timeout_q   <= 1'b0;
         best_id_q   <= '0;
         best_cost_q <= AllOnes;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  num_q      <= num_clamped;
                  thr_q      <= bus.cost_threshold;
                  cand_cnt_q <= '0;
                  min_q      <= AllOnes;
                  min_id_q   <= '0;
                  to_cnt_q   <= '0;
                  to_flag_q  <= 1'b0;
                  ready_q    <= 1'b0;
                  state_q    <= (num_clamped == '0) ? StDecide : StCollect;
               end
            end
            StCollect: begin
               if (bus.valid_iou) begin
                  cand_cnt_q <= cand_cnt_d;
                  min_q      <= min_d;
                  min_id_q   <= min_id_d;
                  to_cnt_q   <= '0;
                  if (cand_cnt_d == num_q) begin
                     state_q <= StDecide;
                  end
               end else if (to_cnt_q == ToLast) begin
                  to_cnt_q  <= to_cnt_d;
                  to_flag_q <= 1'b1;
                  state_q   <= StDecide;
               end else begin
                  to_cnt_q <= to_cnt_d;
               end
            end
            StDecide: begin
               best_cost_q <= min_q;
               best_id_q   <= min_id_q;
               match_q     <= (cand_cnt_q != '0) && (min_q <= thr_q);
               timeout_q   <= to_flag_q;
               done_q      <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.ready       = ready_q;
   assign bus.done        = done_q;
   assign bus.match_found = match_q;
   assign bus.best_id     = best_id_q;
   assign bus.best_cost   = best_cost_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_oflow_iou_best_match.sv
// Directed bench for oflow_iou_best_match: hand-computed expectations for
// basic match, threshold/tie, zero candidates, timeout, 16 spaced candidates
// and reset during collection.
module tb_oflow_iou_best_match;

   logic clk;
   logic reset_N;
   int   n_tests;
   int   n_fail;

   oflow_iou_best_match_if bus ();

   oflow_iou_best_match dut (
      .clk     (clk),
      .reset_N (reset_N),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [4:0] num, input logic [21:0] thr);
      check("ready_before_start", 32'(bus.ready), 32'd1);
      bus.start          = 1'b1;
      bus.num_candidates = num;
      bus.cost_threshold = thr;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic strobe(input logic [21:0] cost);
      bus.valid_iou = 1'b1;
      bus.iou       = cost;
      tick();
      bus.valid_iou = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [3:0] id, input logic [21:0] cost,
                               input logic match, input logic to);
      check({tag, "_done"},    32'(bus.done),        32'd1);
      check({tag, "_best_id"}, 32'(bus.best_id),     32'(id));
      check({tag, "_cost"},    32'(bus.best_cost),   32'(cost));
      check({tag, "_match"},   32'(bus.match_found), 32'(match));
      check({tag, "_timeout"}, 32'(bus.timeout),     32'(to));
   endtask

   initial begin
      int  early;
      int  seen;
      n_tests            = 0;
      n_fail             = 0;
      reset_N            = 1'b0;
      bus.start          = 1'b0;
      bus.num_candidates = '0;
      bus.cost_threshold = '0;
      bus.valid_iou      = 1'b0;
      bus.iou            = '0;
      #12;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_done",  32'(bus.done), 32'd0);
      check("rst_match", 32'(bus.match_found), 32'd0);
      check("rst_id",    32'(bus.best_id), 32'd0);
      check("rst_cost",  32'(bus.best_cost), 32'h3FFFFF);
      check("rst_to",    32'(bus.timeout), 32'd0);
      reset_N = 1'b1;
      tick();

      // Basic match: min 0x0A0000 at index 1.
      do_start(5'd4, 22'h100000);
      check("basic_ready_low", 32'(bus.ready), 32'd0);
      strobe(22'h300000);
      strobe(22'h0A0000);
      strobe(22'h1F0000);
      strobe(22'h3FFFFF);
      check("basic_no_early_done", 32'(bus.done), 32'd0);
      tick();
      check_result("basic", 4'd1, 22'h0A0000, 1'b1, 1'b0);
      tick();
      check("basic_done_pulse", 32'(bus.done), 32'd0);
      check("basic_ready_back", 32'(bus.ready), 32'd1);
      check("basic_hold_cost", 32'(bus.best_cost), 32'h0A0000);

      // Tie keeps index 0; 0x080000 > 0x050000 so no match.
      do_start(5'd3, 22'h050000);
      strobe(22'h080000);
      strobe(22'h080000);
      strobe(22'h090000);
      tick();
      check_result("tie", 4'd0, 22'h080000, 1'b0, 1'b0);
      tick();

      // Zero candidates: start edge -> DECIDE, next edge -> done.
      do_start(5'd0, 22'h3FFFFF);
      seen = 0;
      for (int i = 0; i < 2 && seen == 0; i++) begin
         tick();
         if (bus.done) seen = 1;
      end
      check("zero_done_within_2", 32'(seen), 32'd1);
      check_result("zero", 4'd0, 22'h3FFFFF, 1'b0, 1'b0);
      tick();
      check("zero_ready_back", 32'(bus.ready), 32'd1);

      // Timeout: 64 idle edges reach DECIDE, done on the 65th.
      do_start(5'd5, 22'h3FFFFF);
      strobe(22'h020000);
      strobe(22'h010000);
      early = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (bus.done) early = 1;
      end
      check("to_no_early_done", 32'(early), 32'd0);
      tick();
      check_result("to", 4'd1, 22'h010000, 1'b1, 1'b1);
      tick();

      // 16 candidates, decreasing costs, gaps of i%4 cycles; a stray start
      // with num=1 during COLLECT must be ignored.
      do_start(5'd16, 22'h3FFFFF);
      early = 0;
      for (int i = 0; i < 16; i++) begin
         for (int g = 0; g < i % 4; g++) begin
            if (i == 5 && g == 0) begin
               bus.start          = 1'b1;
               bus.num_candidates = 5'd1;
            end
            tick();
            bus.start = 1'b0;
            if (bus.done) early = 1;
         end
         strobe(22'h3FFFF0 - 22'(i));
         if (i < 15 && bus.done) early = 1;
      end
      check("max_no_early_done", 32'(early), 32'd0);
      tick();
      check_result("max", 4'd15, 22'h3FFFE1, 1'b1, 1'b0);
      tick();

      // Reset mid-COLLECT: async clear, no done afterwards.
      do_start(5'd4, 22'h3FFFFF);
      strobe(22'h001000);
      strobe(22'h000800);
      reset_N = 1'b0;
      #1;
      check("rstmid_ready", 32'(bus.ready), 32'd1);
      check("rstmid_id",    32'(bus.best_id), 32'd0);
      check("rstmid_cost",  32'(bus.best_cost), 32'h3FFFFF);
      check("rstmid_match", 32'(bus.match_found), 32'd0);
      check("rstmid_done",  32'(bus.done), 32'd0);
      #3;
      reset_N = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.done) seen = 1;
      end
      check("rstmid_no_done", 32'(seen), 32'd0);
      do_start(5'd2, 22'h100000);
      strobe(22'h050000);
      strobe(22'h040000);
      tick();
      check_result("post_rst", 4'd1, 22'h040000, 1'b1, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
